coe_serializer: RTL and testbench
=================================

# coe_serializer

Bit-serial transmitter for the coefficient accumulator datapath. It accepts one parallel frame of NUM_COE_ARRAY coefficient words through a valid/ready handshake. It then shifts the frame out one bit-plane per cycle on a NUM_COE_ARRAY-wide bus, driving the `accumulation`, `input_selection` and `sign_ctrl` inputs of the bit-serial accumulator. Frame markers let downstream logic align to word boundaries.

## Interface
- NUM_COE_ARRAY, 16, number of parallel lanes (one coefficient per lane)
- INPUT_SEL_WIDTH, 4, width of lane-select field; log2(NUM_COE_ARRAY) <= INPUT_SEL_WIDTH
- DATA_WIDTH, 8, bits per coefficient word; must be >= 2
- CNT_WIDTH, $clog2(DATA_WIDTH), bit-counter width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  frame offered
- in_ready  out  1  frame can be accepted this cycle
- in_data  in  NUM_COE_ARRAY*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_sel  in  INPUT_SEL_WIDTH  lane to be accumulated for this frame
- in_sign  in  1  sign control for this frame
- hold  in  1  downstream stall; freezes shifting
- bit_out  out  NUM_COE_ARRAY  current bit-plane, bit i = lane i
- sel_out  out  INPUT_SEL_WIDTH  latched in_sel, constant for the frame
- sign_out  out  1  latched in_sign, constant for the frame
- frame_start  out  1  high with bit-plane 0 of a frame
- frame_last  out  1  high with bit-plane DATA_WIDTH-1
- busy  out  1  a frame is being shifted

## Operation
- States: IDLE and SHIFT.
- IDLE:
  - in_ready=1, busy=0, bit_out/frame flags=0.
  - sel_out and sign_out hold their last values.
- Accept occurs when in_valid && in_ready is sampled at a rising edge.
  - On accept: load all lanes into per-lane shift registers, latch in_sel/in_sign, clear the bit counter, go to SHIFT.
- SHIFT:
  - bit_out[i] = current bit of lane i; busy=1.
  - frame_start = (cnt==0); frame_last = (cnt==DATA_WIDTH-1).
  - The counter advances and the registers shift only when hold=0.
- Leaving SHIFT, when hold=0 and cnt==DATA_WIDTH-1:
  - in_ready=1 combinationally.
  - If in_valid, the next frame loads and SHIFT continues with cnt=0 (back-to-back, no bubble).
  - Otherwise go to IDLE.
- In SHIFT and not in the last-plane cycle, in_ready=0.
  - In the last-plane cycle with hold=1, in_ready=0.
- While hold=1, all outputs stay frozen, including frame flags.
- Counter wrap: DATA_WIDTH-1 -> 0 only through an accept; it never free-runs.
- Default bit order is LSB first.
- in_data is sampled only on the accept edge; later changes to it are ignored.

## Timing
- Reset asserted (asynchronous): state=IDLE, cnt=0, shift registers=0.
  - Output values during reset: bit_out=0, sel_out=0, sign_out=0, frame_start=0, frame_last=0, busy=0.
  - in_ready reads 1 (decoded from IDLE), but no accept occurs while reset is low.
- Reset mid-frame aborts the frame immediately; no partial frame resumes after release.
- Latency: accept at edge T -> bit-plane 0 with frame_start on bit_out during cycle T+1.
  - Plane k appears at cycle T+1+k plus any hold cycles.
  - frame_last appears at T+DATA_WIDTH with no hold.
- Sustained throughput is one frame per DATA_WIDTH cycles.
- hold is sampled at the edge; hold=1 at edge E means the outputs after E equal those before E.
- When in_valid and hold=1 coincide on the last plane: no accept; the frame stays on its last plane until hold drops.
- All outputs are registered, except in_ready, which is decoded from the state, the counter and hold.

## Configuration
- COE_SER_MSB_FIRST_EN defined: planes shift out MSB first.
  - Plane 0 = bit DATA_WIDTH-1; frame_last marks bit 0.
- Not defined: LSB first (bit 0 with frame_start).
- Handshake, latency and flags are identical in both modes.

## Structure
- Shared package coe_pkg holds:
  - default NUM_COE_ARRAY, INPUT_SEL_WIDTH and DATA_WIDTH constants
  - the state enum (S_IDLE, S_SHIFT)
  - a lane-slice helper function
- One sub-module, coe_lane_shifter: a DATA_WIDTH parallel-load shift register with load/shift enables and the configurable bit order.
  - It is instantiated NUM_COE_ARRAY times via generate.
- The FSM, counter and handshake logic live in the top module.

## Test plan
- Reset release, then one frame: lane0=8'hA5, in_sel=3, in_sign=1, hold=0.
  - bit_out[0] over cycles T+1..T+8 = 1,0,1,0,0,1,0,1.
  - frame_start at T+1, frame_last at T+8; sel_out=3 and sign_out=1 throughout; busy drops at T+9.
- Back-to-back frames with in_valid held high: 16 consecutive planes with no gap.
  - in_ready is high only in the frame_last cycle.
  - frame_start follows frame_last in the next cycle.
- hold=1 for 3 cycles at plane 4: bit_out/frame flags frozen for 3 cycles.
  - frame_last arrives at T+11.
  - in_valid during the held last plane is not accepted until hold=0.
- Reset low at plane 5, released after 2 cycles: all outputs 0 immediately, state IDLE, in_ready=1.
  - The next frame starts cleanly at plane 0.
- With COE_SER_MSB_FIRST_EN and lane0=8'h81 (all other lanes 8'h00): the lane-0 sequence is 1,0,0,0,0,0,0,1; all other lanes stay 0.
- Random in_data across all 16 lanes: the reassembled words match the inputs in both bit orders.

Source files
------------

// File: rtl/coe_pkg.sv
// Shared definitions for the coefficient bit-serial transmitter.
// Default lane geometry, FSM state encoding and the lane-slice helper.
package coe_pkg;

  localparam int unsigned COE_NUM_LANES  = 16;
  localparam int unsigned COE_SEL_WIDTH  = 4;
  localparam int unsigned COE_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } coe_state_t;

  // Lowest bit index of a lane inside the flattened coefficient bus.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/coe_lane_shifter.sv
// One coefficient lane: parallel-load shift register presenting one bit per plane.
// Bit order: LSB first by default; MSB first when COE_SER_MSB_FIRST_EN is defined.
// Zeros are shifted in, so the register drains to all-zero once a frame has
// been shifted out and bit_out reads 0 while the serializer idles.
module coe_lane_shifter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  bit_out
);

  logic [DATA_WIDTH-1:0] sr;

  // Load takes precedence over shift so a back-to-back frame replaces the drained word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
`ifdef COE_SER_MSB_FIRST_EN
      sr <= {sr[DATA_WIDTH-2:0], 1'b0};
`else
      sr <= {1'b0, sr[DATA_WIDTH-1:1]};
`endif
    end
  end

`ifdef COE_SER_MSB_FIRST_EN
  assign bit_out = sr[DATA_WIDTH-1];
`else
  assign bit_out = sr[0];
`endif

endmodule

// File: rtl/coe_serializer.sv
// Bit-serial coefficient transmitter: accepts a parallel frame over valid/ready
// and emits one bit-plane per cycle with frame markers and latched sel/sign.
// Bit order selected by COE_SER_MSB_FIRST_EN (undefined: LSB first).
module coe_serializer
  import coe_pkg::*;
#(
  parameter int unsigned NUM_COE_ARRAY   = COE_NUM_LANES,
  parameter int unsigned INPUT_SEL_WIDTH = COE_SEL_WIDTH,
  parameter int unsigned DATA_WIDTH      = COE_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH       = $clog2(DATA_WIDTH)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_COE_ARRAY*DATA_WIDTH-1:0] in_data,
  input  logic [INPUT_SEL_WIDTH-1:0]          in_sel,
  input  logic                                in_sign,
  input  logic                                hold,
  output logic [NUM_COE_ARRAY-1:0]            bit_out,
  output logic [INPUT_SEL_WIDTH-1:0]          sel_out,
  output logic                                sign_out,
  output logic                                frame_start,
  output logic                                frame_last,
  output logic                                busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  coe_state_t           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 last_plane;
  logic                 accept;
  logic                 advance;

  assign cnt_next   = cnt + CNT_WIDTH'(1);
  assign last_plane = (state == S_SHIFT) && (cnt == CNT_LAST);
  assign in_ready   = (state == S_IDLE) || (last_plane && !hold);
  assign accept     = in_valid && in_ready;
  assign advance    = (state == S_SHIFT) && !hold;

  // Frame control: state, bit counter, latched sideband and registered flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sel_out     <= '0;
      sign_out    <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
      busy        <= 1'b0;
    end else if (accept) begin
      state       <= S_SHIFT;
      cnt         <= '0;
      sel_out     <= in_sel;
      sign_out    <= in_sign;
      frame_start <= 1'b1;
      frame_last  <= 1'b0;
      busy        <= 1'b1;
    end else if (advance) begin
      frame_start <= 1'b0;
      if (last_plane) begin
        state      <= S_IDLE;
        cnt        <= '0;
        frame_last <= 1'b0;
        busy       <= 1'b0;
      end else begin
        cnt        <= cnt_next;
        frame_last <= (cnt_next == CNT_LAST);
      end
    end
  end

  for (genvar i = 0; i < NUM_COE_ARRAY; i++) begin : g_lane
    coe_lane_shifter #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
      .clk    (clk),
      .reset  (reset),
      .load   (accept),
      .shift  (advance),
      .din    (in_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .bit_out(bit_out[i])
    );
  end

endmodule

// File: tb/tb_coe_serializer.sv
// Self-checking bench for coe_serializer: accepted frames are expanded into
// expected bit-planes on a queue and popped as the DUT presents each plane.
module tb_coe_serializer;
  import coe_pkg::*;

  localparam int unsigned NL = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [NL*DW-1:0] in_data;
  logic [SW-1:0]   in_sel;
  logic            in_sign;
  logic            hold;
  logic [NL-1:0]   bit_out;
  logic [SW-1:0]   sel_out;
  logic            sign_out;
  logic            frame_start;
  logic            frame_last;
  logic            busy;

  always #5 clk = ~clk;

  coe_serializer #(
    .NUM_COE_ARRAY  (NL),
    .INPUT_SEL_WIDTH(SW),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_sign    (in_sign),
    .hold       (hold),
    .bit_out    (bit_out),
    .sel_out    (sel_out),
    .sign_out   (sign_out),
    .frame_start(frame_start),
    .frame_last (frame_last),
    .busy       (busy)
  );

  typedef struct packed {
    logic [NL-1:0] bits;
    logic          start;
    logic          last;
    logic [SW-1:0] sel;
    logic          sign;
  } plane_t;

  plane_t      sb[$];
  plane_t      cur;
  logic        exp_busy;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [DW-1:0] words [NL];
  logic [NL*DW-1:0] d;
  logic [DW-1:0] seq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned plane_bit(input int unsigned k);
`ifdef COE_SER_MSB_FIRST_EN
    return DW - 1 - k;
`else
    return k;
`endif
  endfunction

  task automatic push_frame(input logic [NL*DW-1:0] fd, input logic [SW-1:0] s, input logic g);
    plane_t r;
    for (int k = 0; k < DW; k++) begin
      for (int i = 0; i < NL; i++) r.bits[i] = fd[i*DW + plane_bit(k)];
      r.start = (k == 0);
      r.last  = (k == DW - 1);
      r.sel   = s;
      r.sign  = g;
      sb.push_back(r);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_busy = 1'b0;
    cur      = '0;
  endtask

  task automatic check_outputs();
    check("bit_out",     bit_out,     cur.bits);
    check("frame_start", frame_start, cur.start);
    check("frame_last",  frame_last,  cur.last);
    check("sel_out",     sel_out,     cur.sel);
    check("sign_out",    sign_out,    cur.sign);
    check("busy",        busy,        exp_busy);
  endtask

  // One clock: check in_ready before the edge, then the registered outputs after it.
  task automatic tick();
    logic rdy;
    logic acc;
    @(negedge clk);
    rdy = !exp_busy || (cur.last && !hold);
    check("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    if (acc) push_frame(in_data, in_sel, in_sign);
    @(posedge clk);
    #1;
    if ((exp_busy && !hold) || (!exp_busy && acc)) begin
      if (sb.size() > 0) begin
        cur      = sb.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_busy   = 1'b0;
        cur.bits   = '0;
        cur.start  = 1'b0;
        cur.last   = 1'b0;
      end
    end
    check_outputs();
  endtask

  function automatic logic [NL*DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_sign = 1'b0; hold = 1'b0;
    model_reset();
    #12;
    check_outputs();
    check("reset_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single frame, lane 0 = A5
    seq = 8'hA5;
    in_data = '0; in_data[DW-1:0] = 8'hA5; in_sel = 4'd3; in_sign = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = rand_data();
    check("a5_lane0", bit_out[0], seq[0]);
    for (int k = 1; k < DW; k++) begin
      tick();
      check("a5_lane0", bit_out[0], seq[k]);
    end
    check("a5_last", frame_last, 1'b1);
    tick();
    check("a5_idle_busy", busy, 1'b0);

    // Lane 0 = 81, all other lanes zero
    seq = 8'h81;
    in_data = '0; in_data[DW-1:0] = 8'h81; in_sel = 4'd9; in_sign = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < DW; k++) begin
      if (k > 0) tick();
      check("h81_lane0", bit_out[0], seq[k]);
      check("h81_others", bit_out[NL-1:1], '0);
    end
    tick();

    // Back-to-back frames with in_valid held high
    in_valid = 1'b1;
    for (int c = 0; c < 2*DW; c++) begin
      in_data = rand_data(); in_sel = SW'($urandom_range(0, 15)); in_sign = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    repeat (DW) tick();

    // Hold for three cycles at plane 4, then hold on the last plane with in_valid
    in_data = rand_data(); in_sel = 4'd5; in_sign = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    hold = 1'b1;
    repeat (3) tick();
    hold = 1'b0;
    repeat (3) tick();
    check("hold_last_t11", frame_last, 1'b1);
    hold = 1'b1; in_valid = 1'b1; in_data = rand_data(); in_sel = 4'd12; in_sign = 1'b0;
    repeat (2) tick();
    check("held_ready", in_ready, 1'b0);
    hold = 1'b0;
    tick();
    check("post_hold_start", frame_start, 1'b1);
    in_valid = 1'b0;
    repeat (DW) tick();

    // Reset in the middle of a frame
    in_data = rand_data(); in_sel = 4'd7; in_sign = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check("midreset_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_data = rand_data(); in_sel = 4'd2; in_sign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    check("restart_start", frame_start, 1'b1);
    in_valid = 1'b0;
    repeat (DW) tick();

    // Random frames, reassembled from the serial planes
    for (int f = 0; f < 3; f++) begin
      d = rand_data();
      in_data = d; in_sel = SW'($urandom_range(0, 15)); in_sign = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_data = ~d;
      for (int k = 0; k < DW; k++) begin
        if (k > 0) tick();
        for (int i = 0; i < NL; i++) words[i][plane_bit(k)] = bit_out[i];
      end
      for (int i = 0; i < NL; i++) check("reassembled", words[i], d[i*DW +: DW]);
    end
    tick();
    check("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
